cause_encoder32: RTL



---
 rtl/cause_encoder32_pkg.sv | 24 ++
 rtl/cause_encoder32_if.sv | 25 ++
 rtl/cause_encoder32_prio_enc32.sv | 34 +++
 rtl/cause_encoder32.sv | 72 +++++++
 4 files changed

// File: rtl/cause_encoder32_pkg.sv
// Shared constants, FSM encoding and helpers for the 32:5 cause encoder.
package cause_encoder32_pkg;

   localparam int IDX_W = 5;
   localparam int N_REQ = 32;
   localparam int GRP_W = 8;
   localparam int N_GRP = N_REQ / GRP_W;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_e;

   // Lowest set bit of an 8-bit group; 0 when the group is empty.
   function automatic logic [2:0] enc8(input logic [GRP_W-1:0] v);
      logic [2:0] r;
      r = '0;
      for (int i = GRP_W - 1; i >= 0; i--) begin
         if (v[i]) r = 3'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/cause_encoder32_if.sv
// Request/selection bundle between cause sources, encoder and control FSM.
interface cause_encoder32_if
   import cause_encoder32_pkg::*;
   ();

   logic             en;
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] mask;
   logic             ack;
   logic             valid;
   logic [IDX_W-1:0] idx;
   logic [N_REQ-1:0] pending;
   logic             any_eligible;

   modport master (
      input  en, req, mask, ack,
      output valid, idx, pending, any_eligible
   );

   modport slave (
      output en, req, mask, ack,
      input  valid, idx, pending, any_eligible
   );

endinterface

// File: rtl/cause_encoder32_prio_enc32.sv
// Lowest-set-bit 32:5 priority encoder, built as 4 x 8:3 plus a 4:2 group pick.
module prio_enc32
   import cause_encoder32_pkg::*;
(
   input  logic [N_REQ-1:0] vec,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   logic [N_GRP-1:0] g_hit;
   logic [N_GRP-1:0] g_sel;
   logic [2:0]       g_idx [N_GRP];

   for (genvar g = 0; g < N_GRP; g++) begin : g_grp
      assign g_hit[g] = |vec[g*GRP_W +: GRP_W];
      assign g_idx[g] = enc8(vec[g*GRP_W +: GRP_W]);
   end

   // Isolate the lowest non-empty group so the select is one-hot.
   assign g_sel = g_hit & (~g_hit + 4'd1);
   assign found = |g_hit;

   always_comb begin
      idx = '0;
      unique case (1'b1)
         g_sel[0]: idx = {2'd0, g_idx[0]};
         g_sel[1]: idx = {2'd1, g_idx[1]};
         g_sel[2]: idx = {2'd2, g_idx[2]};
         g_sel[3]: idx = {2'd3, g_idx[3]};
         default:  idx = '0;
      endcase
   end

endmodule

// File: rtl/cause_encoder32.sv
// Sticky cause capture plus lowest-index selection with valid/ack handshake.
module cause_encoder32
   import cause_encoder32_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   cause_encoder32_if.master        bus
);

   state_e           state_q, state_d;
   logic             valid_q, valid_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [N_REQ-1:0] pending_q, pending_d;
   logic [N_REQ-1:0] clr;
   logic [N_REQ-1:0] eligible;
   logic [IDX_W-1:0] enc_idx;
   logic             enc_found;

   assign eligible = pending_q & ~bus.mask;

   prio_enc32 u_enc (
      .vec   (eligible),
      .idx   (enc_idx),
      .found (enc_found)
   );

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      idx_d   = idx_q;
      clr     = '0;
      unique case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (bus.en && enc_found) begin
               state_d = PRESENT;
               valid_d = 1'b1;
               idx_d   = enc_idx;
            end
         end
         PRESENT: begin
            if (bus.ack) begin
               clr[idx_q] = 1'b1;
               state_d    = IDLE;
               valid_d    = 1'b0;
            end
         end
      endcase
      // A fresh request on the bit being served re-arms it.
      pending_d = (pending_q & ~clr) | bus.req;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         valid_q   <= 1'b0;
         idx_q     <= '0;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
      end
   end

   assign bus.valid        = valid_q;
   assign bus.idx          = idx_q;
   assign bus.pending      = pending_q;
   assign bus.any_eligible = |eligible;

endmodule
